// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single core memory bus between instruction fetch (IF) and load/store (LS).
// One transaction in flight; payload is registered at grant and held until the bus accepts it.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_done_o,
  output logic              if_stall_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  input  logic [STRB_W-1:0] ls_wstrb_i,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              ls_done_o,
  output logic              ls_stall_o,
  output logic              err_o,
  output logic              bus_valid_o,
  input  logic              bus_ready_i,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [STRB_W-1:0] bus_wstrb_o,
  input  logic              bus_resp_valid_i,
  input  logic [DATA_W-1:0] bus_resp_rdata_i,
  input  logic              bus_resp_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_e            state_q;
  logic              owner_q;
  logic              last_grant_q;
  logic              we_q;
  logic              bus_valid_q;
  logic              if_done_q;
  logic              ls_done_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;

  logic if_elig;
  logic ls_elig;
  logic grant_d;
  logic grant_ls_d;

  // A requester in its own done cycle is not eligible, so it cannot be regranted on a stale req.
  always_comb begin
    if_elig    = if_req_i & ~if_done_q;
    ls_elig    = ls_req_i & ~ls_done_q;
    grant_d    = if_elig | ls_elig;
    grant_ls_d = ls_elig & (~if_elig | (last_grant_q == OWN_IF));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_IF;
      we_q         <= 1'b0;
      bus_valid_q  <= 1'b0;
      if_done_q    <= 1'b0;
      ls_done_q    <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
    end else begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_d) begin
            owner_q      <= grant_ls_d;
            last_grant_q <= grant_ls_d;
            addr_q       <= grant_ls_d ? ls_addr_i : if_addr_i;
            we_q         <= grant_ls_d & ls_we_i;
            wdata_q      <= grant_ls_d ? ls_wdata_i : '0;
            wstrb_q      <= (grant_ls_d & ls_we_i) ? ls_wstrb_i : '0;
            bus_valid_q  <= 1'b1;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (bus_ready_i) begin
            bus_valid_q <= 1'b0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          // Write responses leave the LS read-data register untouched.
          if (bus_resp_valid_i) begin
            err_q <= bus_resp_err_i;
            if (owner_q == OWN_LS) begin
              ls_done_q <= 1'b1;
              if (!we_q) begin
                ls_rdata_q <= bus_resp_rdata_i;
              end
            end else begin
              if_done_q  <= 1'b1;
              if_rdata_q <= bus_resp_rdata_i;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_done_o   = if_done_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign ls_done_o   = ls_done_q;
  assign err_o       = err_q;
  assign bus_valid_o = bus_valid_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_wstrb_o = wstrb_q;

  // Stalls drop in the done cycle itself so the pipeline advances without an extra bubble.
  assign if_stall_o  = if_req_i & ~if_done_q;
  assign ls_stall_o  = ls_req_i & ~ls_done_q;

endmodule
